muldiv_seq_unit: RTL and testbench

Parametrised, multi-cycle integer multiply/divide unit for the execute stage. It accepts one RV M-extension operation (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) through a valid/ready handshake. It computes the result iteratively, one bit per cycle, and returns it with a caller-supplied tag through a second valid/ready handshake. It sits beside the single-cycle ALU op set; a flush input lets the pipeline kill an in-flight operation on redirect.

---
 rtl/muldiv_seq_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_seq_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_unit
//  Description : Iterative RV M-extension multiply/divide unit. One bit per
//                cycle (shift-add multiply, restoring divide), valid/ready on
//                both sides, tag pass-through and pipeline flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int                   c_CNT_W  = $clog2(XLEN + 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LD = c_CNT_W'(XLEN);
    localparam logic [c_CNT_W-1:0]   c_CNT_1  = c_CNT_W'(1);
    localparam logic [XLEN-1:0]      c_ZERO   = '0;
    localparam logic [XLEN-1:0]      c_ONES   = '1;
    localparam logic [XLEN-1:0]      c_MIN    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0]    c_ZERO2  = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state_q,   w_state_d;
    logic [2:0]          r_op_q,      w_op_d;
    logic                r_neg_res_q, w_neg_res_d;  // negate product / quotient
    logic                r_neg_rem_q, w_neg_rem_d;  // negate remainder
    logic [XLEN-1:0]     r_opnd_q,    w_opnd_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   r_acc_q,     w_acc_d;      // product, or {0, dividend/quotient}
    logic [XLEN:0]       r_rem_q,     w_rem_d;      // partial remainder
    logic [c_CNT_W-1:0]  r_cnt_q,     w_cnt_d;
    logic [XLEN-1:0]     r_result_q,  w_result_d;
    logic [TAG_W-1:0]    r_tag_q,     w_tag_d;

    // Request decode: operand signedness, magnitudes and early-out cases
    logic            w_is_div, w_sign_a_en, w_sign_b_en, w_sign_a, w_sign_b;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res;
    logic            w_b_zero, w_ovf, w_special;

    assign w_is_div    = in_op[2];
    assign w_sign_a_en = (in_op == 3'b001) || (in_op == 3'b010) ||
                         (in_op == 3'b100) || (in_op == 3'b110);
    assign w_sign_b_en = (in_op == 3'b001) || (in_op == 3'b100) || (in_op == 3'b110);
    assign w_sign_a    = w_sign_a_en && in_a[XLEN-1];
    assign w_sign_b    = w_sign_b_en && in_b[XLEN-1];
    assign w_a_mag     = w_sign_a ? (c_ZERO - in_a) : in_a;
    assign w_b_mag     = w_sign_b ? (c_ZERO - in_b) : in_b;
    assign w_b_zero    = (in_b == c_ZERO);
    assign w_ovf       = ((in_op == 3'b100) || (in_op == 3'b110)) &&
                         (in_a == c_MIN) && (in_b == c_ONES);
    assign w_special   = w_is_div && (w_b_zero || w_ovf);
    assign w_special_res = w_b_zero ? (in_op[1] ? in_a : c_ONES)
                                    : (in_op[1] ? c_ZERO : in_a);

    // One multiply step: conditionally add multiplicand to the high half, shift right
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc_q[2*XLEN-1:XLEN]} +
                        (r_acc_q[0] ? {1'b0, r_opnd_q} : {1'b0, c_ZERO});
    assign w_mul_next = {w_mul_sum, r_acc_q[XLEN-1:1]};

    // One restoring-divide step: shift in next dividend bit, trial-subtract divisor
    logic [XLEN:0]   w_rem_sh, w_trial, w_rem_next;
    logic            w_fits;
    logic [XLEN-1:0] w_quo_next;
    assign w_rem_sh   = {r_rem_q[XLEN-1:0], r_acc_q[XLEN-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_opnd_q};
    assign w_fits     = ~w_trial[XLEN];
    assign w_rem_next = w_fits ? w_trial : w_rem_sh;
    assign w_quo_next = {r_acc_q[XLEN-2:0], w_fits};

    // Sign correction of the final iteration's values
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s, w_rem_s, w_final;
    assign w_prod_s = r_neg_res_q ? (c_ZERO2 - w_mul_next) : w_mul_next;
    assign w_quo_s  = r_neg_res_q ? (c_ZERO - w_quo_next) : w_quo_next;
    assign w_rem_s  = r_neg_rem_q ? (c_ZERO - w_rem_next[XLEN-1:0]) : w_rem_next[XLEN-1:0];
    assign w_final  = r_op_q[2] ? (r_op_q[1] ? w_rem_s : w_quo_s)
                                : ((r_op_q[1:0] == 2'b00) ? w_prod_s[XLEN-1:0]
                                                          : w_prod_s[2*XLEN-1:XLEN]);

    // Next-state and datapath update
    always_comb begin
        w_state_d   = r_state_q;
        w_op_d      = r_op_q;
        w_neg_res_d = r_neg_res_q;
        w_neg_rem_d = r_neg_rem_q;
        w_opnd_d    = r_opnd_q;
        w_acc_d     = r_acc_q;
        w_rem_d     = r_rem_q;
        w_cnt_d     = r_cnt_q;
        w_result_d  = r_result_q;
        w_tag_d     = r_tag_q;
        case (r_state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    w_op_d      = in_op;
                    w_tag_d     = in_tag;
                    w_neg_res_d = w_sign_a ^ w_sign_b;
                    w_neg_rem_d = w_sign_a;
                    w_opnd_d    = w_is_div ? w_b_mag : w_a_mag;
                    w_acc_d     = {c_ZERO, (w_is_div ? w_a_mag : w_b_mag)};
                    w_rem_d     = '0;
                    if (w_special) begin
                        w_result_d = w_special_res;
                        w_cnt_d    = '0;
                        w_state_d  = S_DONE;
                    end else begin
                        w_cnt_d   = c_CNT_LD;
                        w_state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                w_cnt_d = r_cnt_q - c_CNT_1;
                if (r_op_q[2]) begin
                    w_acc_d = {c_ZERO, w_quo_next};
                    w_rem_d = w_rem_next;
                end else begin
                    w_acc_d = w_mul_next;
                end
                if (r_cnt_q == c_CNT_1) begin
                    w_result_d = w_final;
                    w_state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
        if (flush) begin
            w_state_d = S_IDLE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= S_IDLE;
            r_op_q      <= '0;
            r_neg_res_q <= 1'b0;
            r_neg_rem_q <= 1'b0;
            r_opnd_q    <= '0;
            r_acc_q     <= '0;
            r_rem_q     <= '0;
            r_cnt_q     <= '0;
            r_result_q  <= '0;
            r_tag_q     <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_op_q      <= w_op_d;
            r_neg_res_q <= w_neg_res_d;
            r_neg_rem_q <= w_neg_rem_d;
            r_opnd_q    <= w_opnd_d;
            r_acc_q     <= w_acc_d;
            r_rem_q     <= w_rem_d;
            r_cnt_q     <= w_cnt_d;
            r_result_q  <= w_result_d;
            r_tag_q     <= w_tag_d;
        end
    end

    assign in_ready   = (r_state_q == S_IDLE);
    assign out_valid  = (r_state_q == S_DONE);
    assign out_result = r_result_q;
    assign out_tag    = r_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq_unit
//  Description : Directed self-checking bench for muldiv_seq_unit (XLEN=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_seq_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Present a request for one edge; returns #1 after the accept edge (cycle T+1)
    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Full transaction: latency, result, tag, optional backpressure, handshake
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input int exp_lat, input int hold);
        int lat;
        start(op, a, b, tag);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, out_result, exp);
        check({name, " tag"}, {27'd0, out_tag}, {27'd0, tag});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, " hold valid"}, {31'd0, out_valid}, 32'd1);
            check({name, " hold result"}, out_result, exp);
            check({name, " hold tag"}, {27'd0, out_tag}, {27'd0, tag});
            check({name, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " in_ready after"}, {31'd0, in_ready}, 32'd1);
        check({name, " valid after"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset out_tag", {27'd0, out_tag}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiplies
        run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33, 0);
        run_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 33, 0);
        run_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 33, 0);
        run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 33, 0);
        // Divides
        run_op("DIV",    3'b100, 32'hFFFFFFEC, 32'd6,        5'd7,  32'hFFFFFFFD, 33, 0);
        run_op("REM",    3'b110, 32'hFFFFFFEC, 32'd6,        5'd8,  32'hFFFFFFFE, 33, 0);
        run_op("DIVU",   3'b101, 32'hFFFFFFFF, 32'd16,       5'd9,  32'h0FFFFFFF, 33, 0);
        // Special cases, one cycle
        run_op("DIV0",   3'b100, 32'h00001234, 32'd0,        5'd10, 32'hFFFFFFFF, 1, 0);
        run_op("DIVU0",  3'b101, 32'h00001234, 32'd0,        5'd11, 32'hFFFFFFFF, 1, 0);
        run_op("REM0",   3'b110, 32'h00001234, 32'd0,        5'd12, 32'h00001234, 1, 0);
        run_op("DIVOVF", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1, 0);
        run_op("REMOVF", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 1, 0);
        // Backpressure
        run_op("BP",     3'b101, 32'd100,      32'd7,        5'd21, 32'd14,       33, 5);

        // Flush at T+10 of a DIV
        start(3'b100, 32'd1000, 32'd3, 5'd15);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("flush no result", seen, 0);
        run_op("POSTFLUSH", 3'b100, 32'd100, 32'hFFFFFFF9, 5'd16, 32'hFFFFFFF2, 33, 0);

        // Flush coincident with a request blocks acceptance
        in_op = 3'b101; in_a = 32'd9; in_b = 32'd0; in_tag = 5'd17;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flushacc in_ready", {31'd0, in_ready}, 32'd1);
        check("flushacc valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-BUSY
        start(3'b000, 32'd11, 32'd13, 5'd18);
        repeat (5) @(posedge clk);
        #2;
        check("busy in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("POSTRST", 3'b000, 32'd11, 32'd13, 5'd19, 32'd143, 33, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
